univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
//
// PURPOSE
// Parametrised universal register: WIDTH-bit storage with synchronous enable,
// hold / shift-left / shift-right / parallel-load modes, and optional rotate.
// Successor to the single-bit enable DFF. Used as a parallel register, serializer
// or deserializer in lab datapaths. A shift counter flags completion of a full
// WIDTH-bit serial transfer.
//
// PARAMETERS
// WIDTH      8      storage width in bits; legal range >= 1
// RESET_VAL  '0     WIDTH-bit value loaded into q on reset
// ROTATE     0      1: shifted-out bit re-enters the opposite end; 0: ser_in enters
//
// PORTS
// clk         in   1          rising-edge clock
// reset       in   1          asynchronous, active-high reset
// enable      in   1          synchronous enable; 0 = full hold
// mode        in   2          00 hold, 01 shift left, 10 shift right, 11 load
// ser_in      in   1          serial input bit (unused when ROTATE=1)
// data        in   WIDTH      parallel load value
// q           out  WIDTH      register contents
// q_n         out  WIDTH      bitwise complement of q, registered alongside q
// ser_out_msb out  1          q[WIDTH-1], combinational from q
// ser_out_lsb out  1          q[0], combinational from q
// shift_cnt   out  CW         shifts since last load/wrap; CW = $clog2(WIDTH+1)
// shift_done  out  1          one-cycle pulse after the WIDTH-th consecutive shift
//
// BEHAVIOUR
// - Reset (async, active-high): q=RESET_VAL, q_n=~RESET_VAL, shift_cnt=0 and
//   shift_done=0. Takes effect immediately, without waiting for clk. Held while
//   reset=1. Reset wins over a coincident clk edge.
// - All other state updates occur on posedge clk only. Latency is 1 cycle:
//   q reflects inputs sampled at edge N immediately after edge N.
// - enable=0: q, q_n and shift_cnt hold; shift_done=0 on that edge.
// - enable=1, mode:
//   00 hold     : q, shift_cnt unchanged.
//   01 shl      : q <= {q[W-2:0], in}. in = ROTATE ? q[W-1] : ser_in.
//   10 shr      : q <= {in, q[W-1:1]}. in = ROTATE ? q[0] : ser_in.
//   11 load     : q <= data; shift_cnt <= 0 (abandons any partial transfer).
// - q_n is always ~q after every update. Never q==q_n bitwise.
// - Counter: each enabled shift (01/10) increments shift_cnt. Mixed directions
//   both count. Hold does not reset the count.
//   - If shift_cnt==WIDTH-1 at an enabled shift: shift_cnt wraps to 0 and
//     shift_done=1 for the following cycle only.
//   - shift_done is a registered pulse. It goes to 0 on the next edge
//     regardless of enable.
// - WIDTH=1: shl/shr both give q <= in. With ROTATE=1 that is a hold of the
//   value. Every enabled shift pulses shift_done.
// - Unknown/X on mode while enable=1 is a bench error; no recovery is defined.
//
// TESTING (WIDTH=8 unless noted)
// 1 RESET_VAL=8'hA5. Load 8'h3C, then raise reset mid-cycle -> q=8'hA5 and
//   q_n=8'h5A before the next edge; shift_cnt=0.
// 2 Load 8'h81. Apply mode=01, ser_in=0 for 8 edges -> q=02,04,...,80,00;
//   shift_done=1 for exactly the cycle after the 8th edge; shift_cnt=0.
// 3 ROTATE=1. Load 8'h81, then mode=10 for 1 edge -> q=8'hC0. After 8 total
//   shifts -> q=8'h81 and shift_done pulses.
// 4 enable=0, mode=11, data=8'hFF for 3 edges -> q, q_n and shift_cnt
//   unchanged; shift_done=0.
// 5 Shift 3 times (shift_cnt=3), then load 8'h00 -> shift_cnt=0. shift_done
//   stays 0 until 8 further shifts.
// 6 Assert reset coincident with a clk edge while enable=1 and mode=11
//   -> q=RESET_VAL, not data.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal register: hold / shift-left / shift-right / parallel load with optional
// rotate, a registered complement output and a full-transfer completion pulse.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               ROTATE    = 1'b0,
    localparam int              CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             ser_out_msb,
    output logic             ser_out_lsb,
    output logic [CW-1:0]    shift_cnt,
    output logic             shift_done
);
    localparam logic [1:0]    MODE_HOLD = 2'b00;
    localparam logic [1:0]    MODE_SHL  = 2'b01;
    localparam logic [1:0]    MODE_SHR  = 2'b10;
    localparam logic [1:0]    MODE_LOAD = 2'b11;
    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);

    logic             shl_in;
    logic             shr_in;
    logic [WIDTH-1:0] q_shl;
    logic [WIDTH-1:0] q_shr;
    logic [WIDTH-1:0] q_next;
    logic             do_shift;
    logic             do_load;

    // With ROTATE the bit leaving one end re-enters at the other.
    assign shl_in = ROTATE ? q[WIDTH-1] : ser_in;
    assign shr_in = ROTATE ? q[0]       : ser_in;

    generate
        if (WIDTH == 1) begin : g_w1
            assign q_shl = shl_in;
            assign q_shr = shr_in;
        end else begin : g_wn
            assign q_shl = {q[WIDTH-2:0], shl_in};
            assign q_shr = {shr_in, q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        q_next   = q;
        do_shift = 1'b0;
        do_load  = 1'b0;
        if (enable) begin
            case (mode)
                MODE_HOLD: q_next = q;
                MODE_SHL: begin
                    q_next   = q_shl;
                    do_shift = 1'b1;
                end
                MODE_SHR: begin
                    q_next   = q_shr;
                    do_shift = 1'b1;
                end
                MODE_LOAD: begin
                    q_next  = data;
                    do_load = 1'b1;
                end
            endcase
        end
    end

    // q_n is registered from the same next value so it never disagrees with q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q          <= RESET_VAL;
            q_n        <= ~RESET_VAL;
            shift_cnt  <= '0;
            shift_done <= 1'b0;
        end else begin
            q          <= q_next;
            q_n        <= ~q_next;
            shift_done <= 1'b0;
            if (do_load) begin
                shift_cnt <= '0;
            end else if (do_shift) begin
                if (shift_cnt == CNT_LAST) begin
                    shift_cnt  <= '0;
                    shift_done <= 1'b1;
                end else begin
                    shift_cnt <= shift_cnt + CW'(1);
                end
            end
        end
    end

    assign ser_out_msb = q[WIDTH-1];
    assign ser_out_lsb = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: two WIDTH=8 instances (shift-in and rotate) driven in
// lockstep, checked against a scoreboard filled by a behavioural model.
module tb_univ_shift_reg;
    logic       clk;
    logic       reset;
    logic       enable;
    logic [1:0] mode;
    logic       ser_in;
    logic [7:0] data;

    logic [7:0] q0, qn0, q1, qn1;
    logic       msb0, lsb0, msb1, lsb1;
    logic [3:0] cnt0, cnt1;
    logic       done0, done1;

    logic [22:0] obs0, obs1;
    logic [45:0] sb[$];
    logic [7:0]  mq[2];
    logic [3:0]  mc[2];
    int total = 0;
    int bad = 0;

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .ROTATE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .ser_in(ser_in),
        .data(data), .q(q0), .q_n(qn0), .ser_out_msb(msb0), .ser_out_lsb(lsb0),
        .shift_cnt(cnt0), .shift_done(done0)
    );

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .ROTATE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .ser_in(ser_in),
        .data(data), .q(q1), .q_n(qn1), .ser_out_msb(msb1), .ser_out_lsb(lsb1),
        .shift_cnt(cnt1), .shift_done(done1)
    );

    assign obs0 = {q0, qn0, msb0, lsb0, cnt0, done0};
    assign obs1 = {q1, qn1, msb1, lsb1, cnt1, done1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [22:0] pk(input logic [7:0] q, input logic [3:0] c, input logic d);
        return {q, ~q, q[7], q[0], c, d};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            mq[r] = 8'hA5;
            mc[r] = 4'd0;
        end
    endtask

    // Drive one cycle of stimulus, push the model's expectation, wait past the edge.
    task automatic step(input logic en, input logic [1:0] md, input logic sin, input logic [7:0] d);
        logic [22:0] ev[2];
        logic [7:0]  nq;
        logic        dn;
        logic        ib;
        enable = en;
        mode   = md;
        ser_in = sin;
        data   = d;
        for (int r = 0; r < 2; r++) begin
            nq = mq[r];
            dn = 1'b0;
            if (en) begin
                if (md == 2'b11) begin
                    nq    = d;
                    mc[r] = 4'd0;
                end else if (md != 2'b00) begin
                    if (md == 2'b01) begin
                        ib = (r == 1) ? mq[r][7] : sin;
                        nq = (mq[r] << 1) | {7'd0, ib};
                    end else begin
                        ib = (r == 1) ? mq[r][0] : sin;
                        nq = (mq[r] >> 1) | (ib ? 8'h80 : 8'h00);
                    end
                    if (mc[r] == 4'd7) begin
                        mc[r] = 4'd0;
                        dn    = 1'b1;
                    end else begin
                        mc[r] = mc[r] + 4'd1;
                    end
                end
            end
            mq[r] = nq;
            ev[r] = pk(nq, mc[r], dn);
        end
        sb.push_back({ev[1], ev[0]});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [22:0] e;
        e = pk(8'hA5, 4'd0, 1'b0);
        #2;
        total++;
        if (obs0 !== e) begin bad++; $display("FAIL reset_dut0 got %h want %h", obs0, e); end
        total++;
        if (obs1 !== e) begin bad++; $display("FAIL reset_dut1 got %h want %h", obs1, e); end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [45:0] e;
        logic [22:0] er;
        step(1'b1, 2'b11, 1'b0, 8'h3C);
        e = sb.pop_front();
        total++;
        if (obs0 !== e[22:0]) begin bad++; $display("FAIL load3c_dut0 got %h want %h", obs0, e[22:0]); end
        step(1'b1, 2'b01, 1'b1, 8'h00);
        e = sb.pop_front();
        total++;
        if (obs0 !== e[22:0]) begin bad++; $display("FAIL shift_pre_reset_dut0 got %h want %h", obs0, e[22:0]); end
        #3;
        reset = 1'b1;
        #1;
        er = pk(8'hA5, 4'd0, 1'b0);
        total++;
        if (obs0 !== er) begin bad++; $display("FAIL async_reset_dut0 got %h want %h", obs0, er); end
        total++;
        if (obs1 !== er) begin bad++; $display("FAIL async_reset_dut1 got %h want %h", obs1, er); end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_shl();
        logic [45:0] e;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, (i == 0) ? 2'b11 : ((i < 9) ? 2'b01 : 2'b00), 1'b0, 8'h81);
            e = sb.pop_front();
            total++;
            if (obs0 !== e[22:0]) begin bad++; $display("FAIL shl_dut0 step %0d got %h want %h", i, obs0, e[22:0]); end
            total++;
            if (obs1 !== e[45:23]) begin bad++; $display("FAIL shl_dut1 step %0d got %h want %h", i, obs1, e[45:23]); end
        end
    endtask

    task automatic test_rotate();
        logic [45:0] e;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, (i == 0) ? 2'b11 : ((i < 9) ? 2'b10 : 2'b00), 1'b1, 8'h81);
            e = sb.pop_front();
            total++;
            if (obs1 !== e[45:23]) begin bad++; $display("FAIL rotr_dut1 step %0d got %h want %h", i, obs1, e[45:23]); end
            total++;
            if (obs0 !== e[22:0]) begin bad++; $display("FAIL shr_dut0 step %0d got %h want %h", i, obs0, e[22:0]); end
        end
    endtask

    task automatic test_enable();
        logic [45:0] e;
        for (int i = 0; i < 7; i++) begin
            if (i == 0)      step(1'b1, 2'b11, 1'b0, 8'h5C);
            else if (i < 3)  step(1'b1, 2'b01, 1'b1, 8'h00);
            else if (i < 6)  step(1'b0, 2'b11, 1'b1, 8'hFF);
            else             step(1'b1, 2'b10, 1'b0, 8'hFF);
            e = sb.pop_front();
            total++;
            if (obs0 !== e[22:0]) begin bad++; $display("FAIL enable_dut0 step %0d got %h want %h", i, obs0, e[22:0]); end
            total++;
            if (obs1 !== e[45:23]) begin bad++; $display("FAIL enable_dut1 step %0d got %h want %h", i, obs1, e[45:23]); end
        end
    endtask

    task automatic test_load_abort();
        logic [45:0] e;
        for (int i = 0; i < 13; i++) begin
            if (i < 3)       step(1'b1, 2'b01, 1'b1, 8'hAA);
            else if (i == 3) step(1'b1, 2'b11, 1'b1, 8'h00);
            else             step(1'b1, i[0] ? 2'b01 : 2'b10, 1'b1, 8'h00);
            e = sb.pop_front();
            total++;
            if (obs0 !== e[22:0]) begin bad++; $display("FAIL load_abort_dut0 step %0d got %h want %h", i, obs0, e[22:0]); end
            total++;
            if (obs1 !== e[45:23]) begin bad++; $display("FAIL load_abort_dut1 step %0d got %h want %h", i, obs1, e[45:23]); end
        end
    endtask

    task automatic test_reset_edge();
        logic [22:0] er;
        enable = 1'b1;
        mode   = 2'b11;
        data   = 8'hFF;
        @(posedge clk);
        reset = 1'b1;
        #1;
        er = pk(8'hA5, 4'd0, 1'b0);
        total++;
        if (obs0 !== er) begin bad++; $display("FAIL reset_edge_dut0 got %h want %h", obs0, er); end
        total++;
        if (obs1 !== er) begin bad++; $display("FAIL reset_edge_dut1 got %h want %h", obs1, er); end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [45:0] e;
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)));
            e = sb.pop_front();
            total++;
            if (obs0 !== e[22:0]) begin bad++; $display("FAIL b2b_dut0 step %0d got %h want %h", i, obs0, e[22:0]); end
            total++;
            if (obs1 !== e[45:23]) begin bad++; $display("FAIL b2b_dut1 step %0d got %h want %h", i, obs1, e[45:23]); end
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        mode   = 2'b00;
        ser_in = 1'b0;
        data   = 8'h00;
        test_reset();
        test_async_reset();
        test_shl();
        test_rotate();
        test_enable();
        test_load_abort();
        test_reset_edge();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
